// File: rtl/aes_core_ctrl.sv
// Top-level sequencer for the AES core: launches key expansion and block
// operations, tracks sub-block completion, owns the shared S-box mux.
module aes_core_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init,
    input  logic        next,
    input  logic        encdec,
    input  logic        key_ready,
    input  logic        enc_ready,
    input  logic        dec_ready,
    input  logic [31:0] key_sboxw,
    input  logic [31:0] enc_sboxw,
    output logic [31:0] sboxw,
    output logic        key_init,
    output logic        enc_next,
    output logic        dec_next,
    output logic        cipher_encdec,
    output logic        ready,
    output logic        key_valid,
    output logic        result_valid,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        KEY_START  = 3'd1,
        KEY_WAIT   = 3'd2,
        CIPH_START = 3'd3,
        CIPH_WAIT  = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  wd_r;
    logic        key_init_r;
    logic        enc_next_r;
    logic        dec_next_r;
    logic        cipher_encdec_r;
    logic        ready_r;
    logic        key_valid_r;
    logic        result_valid_r;
    logic        error_r;

    logic [7:0]  wd_next_s;
    logic        watched_ready_s;
    logic        done_s;
    logic        expire_s;
    logic [31:0] sboxw_s;

    // Saturating watchdog increment; the counter never wraps back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc = 8'hFF;
        end else begin
            sat_inc = v + 8'd1;
        end
    endfunction

    // Watchdog next value and completion / expiry decode for the WAIT states.
    always_comb begin
        wd_next_s       = sat_inc(wd_r);
        watched_ready_s = 1'b0;
        case (state_r)
            KEY_WAIT:  watched_ready_s = key_ready;
            CIPH_WAIT: watched_ready_s = cipher_encdec_r ? enc_ready : dec_ready;
            default:   watched_ready_s = 1'b0;
        endcase
        // Ready is stale in the first WAIT cycle, the sub-block only drops it then.
        done_s   = watched_ready_s && (wd_r != 8'd0);
        expire_s = (wd_next_s == TIMEOUT);
    end

    // Shared S-box routing: the encipher block only owns it during its own run.
    always_comb begin
        sboxw_s = key_sboxw;
        if (((state_r == CIPH_START) || (state_r == CIPH_WAIT)) && cipher_encdec_r) begin
            sboxw_s = enc_sboxw;
        end else begin
            sboxw_s = key_sboxw;
        end
    end

    // Sequencer FSM with registered pulse and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            wd_r            <= 8'd0;
            key_init_r      <= 1'b0;
            enc_next_r      <= 1'b0;
            dec_next_r      <= 1'b0;
            cipher_encdec_r <= 1'b0;
            ready_r         <= 1'b1;
            key_valid_r     <= 1'b0;
            result_valid_r  <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            key_init_r <= 1'b0;
            enc_next_r <= 1'b0;
            dec_next_r <= 1'b0;
            error_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (init) begin
                        state_r        <= KEY_START;
                        key_init_r     <= 1'b1;
                        ready_r        <= 1'b0;
                        key_valid_r    <= 1'b0;
                        result_valid_r <= 1'b0;
                    end else if (next) begin
                        if (key_valid_r) begin
                            state_r         <= CIPH_START;
                            cipher_encdec_r <= encdec;
                            enc_next_r      <= encdec;
                            dec_next_r      <= ~encdec;
                            ready_r         <= 1'b0;
                            result_valid_r  <= 1'b0;
                        end else begin
                            error_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                KEY_START: begin
                    wd_r    <= 8'd0;
                    state_r <= KEY_WAIT;
                end
                CIPH_START: begin
                    wd_r    <= 8'd0;
                    state_r <= CIPH_WAIT;
                end
                KEY_WAIT, CIPH_WAIT: begin
                    wd_r <= wd_next_s;
                    // Completion takes priority over a simultaneous expiry.
                    if (done_s) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        if (state_r == KEY_WAIT) begin
                            key_valid_r <= 1'b1;
                        end else begin
                            result_valid_r <= 1'b1;
                        end
                    end else if (expire_s) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        error_r <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign sboxw         = sboxw_s;
    assign key_init      = key_init_r;
    assign enc_next      = enc_next_r;
    assign dec_next      = dec_next_r;
    assign cipher_encdec = cipher_encdec_r;
    assign ready         = ready_r;
    assign key_valid     = key_valid_r;
    assign result_valid  = result_valid_r;
    assign error         = error_r;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Scoreboard bench for aes_core_ctrl: behavioural sub-block models, random
// command stream, expected events queued at issue time and checked by a monitor.
module tb_aes_core_ctrl;

    localparam logic [7:0] T  = 8'd24;
    localparam int         TI = 24;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init, next, encdec;
    logic        key_ready, enc_ready, dec_ready;
    logic [31:0] key_sboxw, enc_sboxw, sboxw;
    logic        key_init, enc_next, dec_next, cipher_encdec;
    logic        ready, key_valid, result_valid, error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Event vector: {key_init, enc_next, dec_next, error, ready, key_valid, result_valid, cipher_encdec}
    typedef struct {
        int         cyc;
        logic [7:0] v;
    } ev_t;
    ev_t exp_q[$];

    logic m_kv = 1'b0, m_rv = 1'b0, m_ce = 1'b0;
    int   win_lo = 1, win_hi = 0;
    bit   mon_en = 1'b0;
    logic prev_rdy = 1'b1;

    int key_busy = 1, enc_busy = 1, dec_busy = 1;
    int key_cnt, enc_cnt, dec_cnt;

    aes_core_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .next(next), .encdec(encdec),
        .key_ready(key_ready), .enc_ready(enc_ready), .dec_ready(dec_ready),
        .key_sboxw(key_sboxw), .enc_sboxw(enc_sboxw), .sboxw(sboxw),
        .key_init(key_init), .enc_next(enc_next), .dec_next(dec_next),
        .cipher_encdec(cipher_encdec), .ready(ready), .key_valid(key_valid),
        .result_valid(result_valid), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sub-block models: ready drops on the edge after the start pulse, busy N cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_cnt <= 0; enc_cnt <= 0; dec_cnt <= 0;
        end else begin
            if (key_init) key_cnt <= key_busy; else if (key_cnt > 0) key_cnt <= key_cnt - 1;
            if (enc_next) enc_cnt <= enc_busy; else if (enc_cnt > 0) enc_cnt <= enc_cnt - 1;
            if (dec_next) dec_cnt <= dec_busy; else if (dec_cnt > 0) dec_cnt <= dec_cnt - 1;
        end
    end
    assign key_ready = (key_cnt == 0);
    assign enc_ready = (enc_cnt == 0);
    assign dec_ready = (dec_cnt == 0);

    initial begin
        key_sboxw = 32'h0;
        enc_sboxw = 32'h0;
        forever begin
            @(posedge clk); #1;
            key_sboxw = $urandom;
            enc_sboxw = $urandom;
        end
    end

    logic [31:0] mon_exp;
    logic [7:0]  mon_obs;
    ev_t         mon_e;

    // Monitor: per-cycle S-box routing check plus event matching against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_exp = (cyc >= win_lo && cyc <= win_hi) ? enc_sboxw : key_sboxw;
                checks++;
                if (sboxw !== mon_exp) begin
                    errors++;
                    $display("FAIL sboxw cyc=%0d got=%h exp=%h", cyc, sboxw, mon_exp);
                end
                mon_obs = {key_init, enc_next, dec_next, error, ready, key_valid, result_valid, cipher_encdec};
                if (key_init || enc_next || dec_next || error || (ready && !prev_rdy)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event cyc=%0d got=%b", cyc, mon_obs);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.cyc != cyc || mon_obs !== mon_e.v) begin
                            errors++;
                            $display("FAIL event got cyc=%0d v=%b exp cyc=%0d v=%b",
                                     cyc, mon_obs, mon_e.cyc, mon_e.v);
                        end
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_event cyc=%0d got=%b exp cyc=%0d v=%b",
                             cyc, mon_obs, exp_q[0].cyc, exp_q[0].v);
                    void'(exp_q.pop_front());
                end
            end
            prev_rdy = ready;
        end
    end

    // Issue one command from IDLE, queue its expected events, then wait it out
    // while driving ignored init/next noise.
    task automatic issue(input logic i_v, input logic n_v, input logic e_v, input int b);
        int c, d;
        @(posedge clk); #1;
        c = cyc;
        d = c;
        key_busy = b; enc_busy = b; dec_busy = b;
        init = i_v; next = n_v; encdec = e_v;
        if (i_v) begin
            exp_q.push_back('{c + 1, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_ce}});
            m_kv = 1'b0; m_rv = 1'b0;
            win_lo = 1; win_hi = 0;
            if (b <= TI - 1) begin
                d = c + 3 + b;
                m_kv = 1'b1;
                exp_q.push_back('{d, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m_ce}});
            end else begin
                d = c + 2 + TI;
                exp_q.push_back('{d, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m_ce}});
            end
        end else if (n_v && m_kv) begin
            m_ce = e_v; m_rv = 1'b0;
            exp_q.push_back('{c + 1, {1'b0, e_v, ~e_v, 1'b0, 1'b0, 1'b1, 1'b0, e_v}});
            if (b <= TI - 1) begin
                d = c + 3 + b;
                m_rv = 1'b1;
                exp_q.push_back('{d, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, m_ce}});
            end else begin
                d = c + 2 + TI;
                exp_q.push_back('{d, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, m_ce}});
            end
            if (e_v) begin
                win_lo = c + 1; win_hi = d - 1;
            end else begin
                win_lo = 1; win_hi = 0;
            end
        end else if (n_v) begin
            d = c + 1;
            exp_q.push_back('{c + 1, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m_rv, m_ce}});
        end
        @(posedge clk); #1;
        while (cyc < d) begin
            init   = 1'($urandom_range(0, 1));
            next   = 1'($urandom_range(0, 1));
            encdec = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        init = 1'b0; next = 1'b0;
    endtask

    int r, s, b;

    initial begin
        reset_n = 1'b0; init = 1'b0; next = 1'b0; encdec = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, key_valid, result_valid, cipher_encdec, key_init, enc_next, dec_next, error} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b",
                     {ready, key_valid, result_valid, cipher_encdec, key_init, enc_next, dec_next, error}, 8'b1000_0000);
        end
        @(posedge clk); #1 mon_en = 1'b1;

        issue(1'b0, 1'b1, 1'b1, 5);        // next without a key: rejected
        issue(1'b1, 1'b0, 1'b0, 20);       // key expansion, 20 busy cycles
        issue(1'b0, 1'b1, 1'b1, 5);        // encipher
        issue(1'b0, 1'b1, 1'b0, 7);        // decipher
        issue(1'b1, 1'b1, 1'b1, 3);        // init wins over next
        issue(1'b0, 1'b1, 1'b1, 200);      // hung encipher: timeout
        issue(1'b0, 1'b1, 1'b1, TI - 1);   // completion on the last allowed cycle
        issue(1'b0, 1'b1, 1'b0, TI);       // ready one cycle too late
        issue(1'b1, 1'b0, 1'b0, TI);       // key timeout leaves key_valid low
        issue(1'b0, 1'b1, 1'b0, 4);        // rejected again
        issue(1'b1, 1'b0, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            s = $urandom_range(0, 9);
            if (s < 6)       b = $urandom_range(1, TI - 1);
            else if (s == 6) b = TI - 1;
            else if (s == 7) b = TI;
            else if (s == 8) b = TI + 1;
            else             b = 1;
            if (r < 3)       issue(1'b1, 1'b0, 1'($urandom_range(0, 1)), b);
            else if (r == 3) issue(1'b1, 1'b1, 1'($urandom_range(0, 1)), b);
            else             issue(1'b0, 1'b1, 1'($urandom_range(0, 1)), b);
        end

        // Asynchronous reset in the middle of a hung encipher run.
        issue(1'b1, 1'b0, 1'b0, 3);
        @(posedge clk); #1;
        mon_en = 1'b0;
        enc_busy = 1000; next = 1'b1; encdec = 1'b1;
        @(posedge clk); #1;
        next = 1'b0;
        checks++;
        if (enc_next !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_enc_next got=%b exp=1", enc_next);
        end
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ready, key_valid, result_valid, cipher_encdec, key_init, enc_next, dec_next, error} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b",
                     {ready, key_valid, result_valid, cipher_encdec, key_init, enc_next, dec_next, error}, 8'b1000_0000);
        end
        @(posedge clk); #3 reset_n = 1'b1;
        exp_q.delete();
        m_kv = 1'b0; m_rv = 1'b0; m_ce = 1'b0;
        win_lo = 1; win_hi = 0;
        @(posedge clk); #1 mon_en = 1'b1;
        issue(1'b0, 1'b1, 1'b1, 5);        // key lost by reset: rejected

        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
